// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcodes, flag bit positions and FSM encoding for alu_multiciclo
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_AND    = 4'b0010;
  localparam logic [3:0] OP_OR     = 4'b0011;
  localparam logic [3:0] OP_XOR    = 4'b0100;
  localparam logic [3:0] OP_NOT    = 4'b0101;
  localparam logic [3:0] OP_SHL    = 4'b0110;
  localparam logic [3:0] OP_SHR    = 4'b0111;
  localparam logic [3:0] OP_MUL    = 4'b1000;
  localparam logic [3:0] OP_DIV    = 4'b1001;
  localparam logic [3:0] OP_MOD    = 4'b1010;
  localparam logic [3:0] OP_EQ     = 4'b1011;
  localparam logic [3:0] OP_CLRBIT = 4'b1100;
  localparam logic [3:0] OP_SETBIT = 4'b1101;
  localparam logic [3:0] OP_NOP_A  = 4'b1110;
  localparam logic [3:0] OP_NOP_B  = 4'b1111;

  localparam int FLAG_N = 7;
  localparam int FLAG_Z = 6;
  localparam int FLAG_C = 5;
  localparam int FLAG_P = 4;
  localparam int FLAG_I = 3;
  localparam int FLAG_D = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_E = 0;

  typedef enum logic [0:0] {
    OCIOSO = 1'b0,
    CALC   = 1'b1
  } estado_t;

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
// ============================================================================
// alu_muldiv_seq : iterative shift-add multiplier / restoring divider
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_muldiv_seq #(
  parameter int LARGURA = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               carga,
  input  logic               modo_div,
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] B,
  output logic               fim,
  output logic [LARGURA-1:0] alto,
  output logic [LARGURA-1:0] baixo
);

  localparam int CW = $clog2(LARGURA + 1);

  logic [CW-1:0]      cnt_q;
  logic               modo_q;
  logic [LARGURA-1:0] m_q, acc_q, q_q;
  logic [LARGURA-1:0] acc_d, q_d;
  logic [LARGURA:0]   soma, desl, dif;

  // alto/baixo expose the post-iteration values so the top can register the
  // final result on the same edge that performs the last iteration.
  always_comb begin
    soma  = {1'b0, acc_q} + {1'b0, (q_q[0] ? m_q : '0)};
    desl  = {acc_q, q_q[LARGURA-1]};
    dif   = desl - {1'b0, m_q};
    acc_d = soma[LARGURA:1];
    q_d   = {soma[0], q_q[LARGURA-1:1]};
    if (modo_q) begin
      if (!dif[LARGURA]) begin
        acc_d = dif[LARGURA-1:0];
        q_d   = {q_q[LARGURA-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[LARGURA-2:0], q_q[LARGURA-1]};
        q_d   = {q_q[LARGURA-2:0], 1'b0};
      end
    end
  end

  assign alto  = acc_d;
  assign baixo = q_d;
  assign fim   = (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      modo_q <= 1'b0;
      m_q    <= '0;
      acc_q  <= '0;
      q_q    <= '0;
    end else if (carga) begin
      cnt_q  <= CW'(LARGURA);
      modo_q <= modo_div;
      m_q    <= B;
      acc_q  <= '0;
      q_q    <= A;
    end else if (cnt_q != '0) begin
      cnt_q  <= cnt_q - CW'(1);
      acc_q  <= acc_d;
      q_q    <= q_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_multiciclo.sv
// ============================================================================
// alu_multiciclo : registered ALU, single-cycle ops plus iterative MUL/DIV/MOD
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_multiciclo
  import alu_pkg::*;
#(
  parameter int LARGURA = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inicio,
  input  logic [3:0]         operacao,
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] B,
  output logic               pronto,
  output logic               valido,
  output logic [LARGURA-1:0] resultado,
  output logic [LARGURA-1:0] resultado_alto,
  output logic [7:0]         flags
);

  localparam logic [LARGURA-1:0] c_um  = LARGURA'(1);
  localparam logic [LARGURA:0]   c_lim = (LARGURA + 1)'(LARGURA);

  estado_t            estado_q;
  logic               pronto_q, valido_q;
  logic [LARGURA-1:0] res_q, alto_q;
  logic [7:0]         flags_q;
  logic [3:0]         op_q;

  logic [LARGURA:0]   w_soma;
  logic [LARGURA-1:0] w_dif, w_mask, w_res, w_alto, m_res, m_alto;
  logic               w_c, w_v, w_e, w_multi, w_carga, m_c;
  logic               w_fim;
  logic [LARGURA-1:0] w_seq_alto, w_seq_baixo;

  function automatic logic [7:0] gera_flags(input logic [LARGURA-1:0] r,
                                            input logic c, input logic v,
                                            input logic e);
    logic [7:0] f;
    f         = '0;
    f[FLAG_N] = r[LARGURA-1];
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = c;
    f[FLAG_P] = ^r;
    f[FLAG_I] = 1'b0;
    f[FLAG_D] = 1'b0;
    f[FLAG_V] = v;
    f[FLAG_E] = e;
    return f;
  endfunction

  always_comb begin
    w_soma = {1'b0, A} + {1'b0, B};
    w_dif  = A - B;
    w_mask = c_um << B;
    w_res  = '0;
    w_alto = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    w_e    = 1'b0;
    case (operacao)
      OP_ADD: begin
        w_res = w_soma[LARGURA-1:0];
        w_c   = w_soma[LARGURA];
        w_v   = (A[LARGURA-1] == B[LARGURA-1]) && (w_soma[LARGURA-1] != A[LARGURA-1]);
      end
      OP_SUB: begin
        w_res = w_dif;
        w_c   = (A < B);
        w_v   = (A[LARGURA-1] != B[LARGURA-1]) && (w_dif[LARGURA-1] != A[LARGURA-1]);
      end
      OP_AND: w_res = A & B;
      OP_OR:  w_res = A | B;
      OP_XOR: w_res = A ^ B;
      OP_NOT: w_res = ~A;
      OP_SHL: begin
        w_res = A << 1;
        w_c   = A[LARGURA-1];
      end
      OP_SHR: begin
        w_res = A >> 1;
        w_c   = A[0];
      end
      // Only reached on the single-cycle path, i.e. divide by zero.
      OP_DIV, OP_MOD: begin
        w_res  = '1;
        w_alto = A;
        w_e    = 1'b1;
      end
      OP_EQ: begin
        w_res = {{(LARGURA-1){1'b0}}, (A == B)};
        w_c   = (A < B);
      end
      OP_CLRBIT: w_res = ({1'b0, B} < c_lim) ? (A & ~w_mask) : A;
      OP_SETBIT: w_res = ({1'b0, B} < c_lim) ? (A | w_mask) : A;
      OP_MUL, OP_NOP_A, OP_NOP_B: w_res = '0;
      default: w_res = '0;
    endcase
  end

  always_comb begin
    m_res  = w_seq_baixo;
    m_alto = w_seq_alto;
    m_c    = 1'b0;
    if (op_q == OP_MUL) begin
      m_c = (w_seq_alto != '0);
    end else if (op_q == OP_MOD) begin
      m_res  = w_seq_alto;
      m_alto = w_seq_baixo;
    end
  end

  assign w_multi = (operacao == OP_MUL) ||
                   (((operacao == OP_DIV) || (operacao == OP_MOD)) && (B != '0));
  assign w_carga = inicio && pronto_q && w_multi;

  alu_muldiv_seq #(
    .LARGURA (LARGURA)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .carga    (w_carga),
    .modo_div (operacao != OP_MUL),
    .A        (A),
    .B        (B),
    .fim      (w_fim),
    .alto     (w_seq_alto),
    .baixo    (w_seq_baixo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      pronto_q <= 1'b1;
      valido_q <= 1'b0;
      res_q    <= '0;
      alto_q   <= '0;
      flags_q  <= 8'h40;
      op_q     <= OP_ADD;
    end else begin
      valido_q <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          if (inicio) begin
            if (w_multi) begin
              estado_q <= CALC;
              pronto_q <= 1'b0;
              op_q     <= operacao;
            end else begin
              res_q    <= w_res;
              alto_q   <= w_alto;
              flags_q  <= gera_flags(w_res, w_c, w_v, w_e);
              valido_q <= 1'b1;
            end
          end
        end
        CALC: begin
          if (w_fim) begin
            res_q    <= m_res;
            alto_q   <= m_alto;
            flags_q  <= gera_flags(m_res, m_c, 1'b0, 1'b0);
            valido_q <= 1'b1;
            estado_q <= OCIOSO;
            pronto_q <= 1'b1;
          end
        end
        default: begin
          estado_q <= OCIOSO;
          pronto_q <= 1'b1;
        end
      endcase
    end
  end

  assign pronto         = pronto_q;
  assign valido         = valido_q;
  assign resultado      = res_q;
  assign resultado_alto = alto_q;
  assign flags          = flags_q;

endmodule

`default_nettype wire

// File: doc/alu_multiciclo.md
# alu_multiciclo

Parametrised, registered ALU with a multi-cycle datapath. It supersedes the 8-bit combinational ALU in the processor datapath. Single-cycle operations return in one clock. Multiply and divide run iteratively over `LARGURA` cycles and return a double-width product, or a quotient/remainder pair. A valid/ready handshake lets the control unit stall on long operations. Flags are registered alongside the result, including carry/borrow, overflow and divide-by-zero.

## Interface
- `LARGURA`, default 8: operand and result width; legal range 4–32.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inicio`  in  1  request valid; accepted when `inicio & pronto` at a rising edge.
- `operacao`  in  4  opcode (see Operation).
- `A`, `B`  in  `LARGURA`  operands; sampled only on accept.
- `pronto`  out  1  idle, able to accept a request.
- `valido`  out  1  one-cycle pulse: `resultado`, `resultado_alto` and `flags` are new.
- `resultado`  out  `LARGURA`  primary result; held until the next result.
- `resultado_alto`  out  `LARGURA`  secondary result; held.
- `flags`  out  8  {N, Z, C, P, I, D, V, E}, bit 7 down to bit 0; held.

## Operation
- All operands are unsigned. N is the result MSB. Z means `resultado == 0`. P is the XOR of all `resultado` bits. I and D are always 0.
- Defaults: C=0, V=0, E=0, `resultado_alto`=0.
- Opcodes:
  - 0000 ADD: C = carry out. V = signed overflow.
  - 0001 SUB: C = borrow (A<B). V = signed overflow (operand signs differ, result sign ≠ A sign).
  - 0010 AND, 0011 OR, 0100 XOR, 0101 NOT A.
  - 0110 SHL by 1: C = A[MSB].
  - 0111 SHR by 1: C = A[0].
  - 1000 MUL: `{resultado_alto, resultado}` = A*B. C = (high half ≠ 0).
  - 1001 DIV: `resultado` = quotient, `resultado_alto` = remainder.
  - 1010 MOD: `resultado` = remainder, `resultado_alto` = quotient.
  - 1011 EQ: `resultado` = (A==B). C = (A<B).
  - 1100 CLRBIT: clear bit B of A.
  - 1101 SETBIT: set bit B of A. For both bit ops, if B ≥ `LARGURA` the result is A unchanged.
  - 1110, 1111 NOP: `resultado`=0, Z=1.
- Divide by zero (1001/1010 with B=0) completes as a single-cycle operation: `resultado` = all ones, `resultado_alto` = A, E=1.
- State machine `OCIOSO` / `CALC`:
  - In `OCIOSO`, `pronto`=1.
  - Accept of a single-cycle opcode: the result is registered at that edge; the FSM stays in `OCIOSO`.
  - Accept of MUL, or of DIV/MOD with B≠0: operands are latched, the counter is loaded with `LARGURA`, and the FSM goes to `CALC`.
  - In `CALC`, `pronto`=0 and one shift-add (MUL) or restoring-subtract (DIV/MOD) iteration runs per edge. When the counter reaches 0, the result is registered and the FSM returns to `OCIOSO`.
- `inicio` while `pronto`=0 is ignored, with no queuing. Input changes during `CALC` have no effect.

## Timing
- Reset state:
  - `OCIOSO`, `pronto`=1, `valido`=0.
  - `resultado`=0, `resultado_alto`=0, `flags`=8'h40 (Z=1).
  - Counter = 0.
- Reset assertion mid-`CALC` aborts the operation immediately. No `valido` pulse follows.
- Latency is measured from the accept edge to the edge at which `valido` is first seen high.
  - Single-cycle operations: 1.
  - MUL, DIV, MOD: `LARGURA`+1. `pronto`=0 for `LARGURA` cycles.
- `pronto` rises in the same cycle `valido` pulses. A new request may be accepted in that cycle, so throughput is 1 per cycle for single-cycle ops and back-to-back multi-cycle ops lose no extra cycle.
- `valido` is high for exactly one cycle per accepted request.

## Structure
- Package `alu_pkg`:
  - opcode localparams.
  - flag bit indices (`FLAG_N` … `FLAG_E`).
  - FSM state encoding.
- Sub-module `alu_muldiv_seq`:
  - interface: `LARGURA` parameter, `clk`, `rst_n`, `carga`, `modo_div`, `A`, `B`, `fim`, `alto`, `baixo`.
  - contains the iteration counter and the shift registers.
- The top level holds the single-cycle combinational logic, the FSM, the output registers and the flag generation.

## Test plan (`LARGURA`=8)
- ADD A=0x7F, B=0x01 -> after 1 cycle `resultado`=0x80; N=1, V=1, C=0, Z=0, P=1; one `valido` pulse.
- SUB A=0x10, B=0x20 -> `resultado`=0xF0, C=1, N=1, P=0, V=0.
- MUL A=200, B=3 -> `pronto` low for 8 cycles, `valido` at cycle 9; `resultado`=0x58, `resultado_alto`=0x02, C=1.
- DIV A=100, B=7 -> `resultado`=14, `resultado_alto`=2. MOD with the same operands -> `resultado`=2, `resultado_alto`=14. DIV A=5, B=0 -> after 1 cycle `resultado`=0xFF, `resultado_alto`=5, E=1.
- Start MUL, pulse `rst_n` low at cycle 4 -> outputs return to reset values, no `valido` pulse, `pronto`=1. Start MUL, hold `inicio` high and change A mid-`CALC` -> the extra request is ignored and the result uses the original operands.
- SETBIT A=0x00, B=9 -> `resultado`=0x00. SETBIT A=0x00, B=3 -> `resultado`=0x08. Back-to-back ADDs on consecutive cycles -> consecutive `valido` pulses.
